// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg
//   Shared constants for the CPU6 / DMA bus arbiter: bus widths, owner
//   encoding, grant-state encoding and the round-robin advance helper.
//   No ports (package).

package bus_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  // Owner encoding seen on the owner output.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;

  // Grant states share the owner encoding so owner is the state register.
  localparam logic [1:0] ST_IDLE = OWN_NONE;
  localparam logic [1:0] ST_CPU  = OWN_CPU;
  localparam logic [1:0] ST_DMA  = OWN_DMA;

  // Next round-robin pointer after idx wins, wrapping modulo num.
  function automatic logic [1:0] rr_advance(input logic [1:0] idx, input int num);
    if (idx == 2'(num - 1)) return 2'd0;
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// bus_arbiter_rr_picker
//   Combinational round-robin priority encoder. Picks the lowest requesting
//   index at or after the rr pointer, wrapping modulo NUM_DMA.
// Ports:
//   req    in  NUM_DMA  request vector
//   rr     in  2        round-robin start pointer (< NUM_DMA)
//   grant  out 2        winning index (valid only when valid=1)
//   valid  out 1        at least one request present

module bus_arbiter_rr_picker #(
  parameter int NUM_DMA = 2
) (
  input  logic [NUM_DMA-1:0] req,
  input  logic [1:0]         rr,
  output logic [1:0]         grant,
  output logic               valid
);

  logic [NUM_DMA-1:0] rot;
  logic [2:0]         sum;

  // Rotate so the rr position lands at bit 0; the first set bit is then
  // the winner counted as an offset from rr.
  assign rot = (req >> rr) | (req << (NUM_DMA - int'(rr)));

  always_comb begin
    grant = 2'd0;
    valid = 1'b0;
    sum   = 3'd0;
    for (int i = 0; i < NUM_DMA; i++) begin
      if (!valid && rot[i]) begin
        valid = 1'b1;
        sum   = 3'(i) + {1'b0, rr};
        if (sum >= 3'(NUM_DMA)) sum = sum - 3'(NUM_DMA);
        grant = sum[1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Shares the 16-bit address / 8-bit data memory bus between CPU6 and
//   NUM_DMA DMA requesters. Round-robin DMA priority, CPU starvation guard
//   (HOLD_MAX), registered bus outputs and registered read return.
//   Optional macro ARB_LOCK_EN adds dma_lock for locked DMA bursts.
// Ports:
//   clock, reset (async, active-high)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request side
//   cpu_ready (comb), cpu_rdata (registered)
//   dma_req/dma_we/dma_addr/dma_wdata  packed DMA request side
//   dma_ack (one-hot pulse while the slot is on the bus), dma_rdata
//   mem_addr/mem_wdata/mem_we (registered bus), mem_rdata (bus read data)
//   owner  current bus slot owner (0 none, 1 CPU, 2 DMA)
//   dma_lock (ARB_LOCK_EN only)  hold the bus for the current DMA owner
//
// state | meaning
// IDLE  | no access driven on the bus this cycle
// CPU   | CPU access on the bus this cycle
// DMA   | DMA access (requester cur_idx) on the bus this cycle

module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_DMA  = 2,
  parameter int HOLD_MAX = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  output logic                      cpu_ready,
  output logic [DATA_W-1:0]         cpu_rdata,
  input  logic [NUM_DMA-1:0]        dma_req,
  input  logic [NUM_DMA-1:0]        dma_we,
  input  logic [ADDR_W*NUM_DMA-1:0] dma_addr,
  input  logic [DATA_W*NUM_DMA-1:0] dma_wdata,
`ifdef ARB_LOCK_EN
  input  logic [NUM_DMA-1:0]        dma_lock,
`endif
  output logic [NUM_DMA-1:0]        dma_ack,
  output logic [DATA_W-1:0]         dma_rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_we,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [1:0]                owner
);

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  logic [1:0]         state, nxt_state;
  logic [1:0]         cur_idx, nxt_idx;
  logic [1:0]         rr, nxt_rr;
  logic [7:0]         starve, nxt_starve;
  logic               pick_valid;
  logic [1:0]         pick_idx;
  logic               lock_hit;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_we;
  logic [NUM_DMA-1:0] sel_ack;

  bus_arbiter_rr_picker #(.NUM_DMA(NUM_DMA)) u_picker (
    .req   (dma_req),
    .rr    (rr),
    .grant (pick_idx),
    .valid (pick_valid)
  );

`ifdef ARB_LOCK_EN
  // The current DMA owner keeps the bus while it still requests with lock.
  always_comb begin
    lock_hit = 1'b0;
    for (int i = 0; i < NUM_DMA; i++) begin
      if (state == ST_DMA && cur_idx == 2'(i) && dma_lock[i] && dma_req[i])
        lock_hit = 1'b1;
    end
  end
`else
  assign lock_hit = 1'b0;
`endif

  always_comb begin
    nxt_state  = ST_IDLE;
    nxt_idx    = cur_idx;
    nxt_rr     = rr;
    nxt_starve = starve;
    if (cpu_req && starve == HOLD_LIM) begin
      nxt_state  = ST_CPU;
      nxt_starve = 8'd0;
    end else if (lock_hit || pick_valid) begin
      nxt_state = ST_DMA;
      // A locked burst keeps the owner and freezes the rr pointer.
      if (!lock_hit) begin
        nxt_idx = pick_idx;
        nxt_rr  = rr_advance(pick_idx, NUM_DMA);
      end
      if (cpu_req && starve != HOLD_LIM) nxt_starve = starve + 8'd1;
    end else if (cpu_req) begin
      nxt_state  = ST_CPU;
      nxt_starve = 8'd0;
    end
  end

  always_comb begin
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    sel_we    = cpu_we;
    sel_ack   = '0;
    if (nxt_state == ST_DMA) begin
      for (int i = 0; i < NUM_DMA; i++) begin
        if (nxt_idx == 2'(i)) begin
          sel_addr   = dma_addr[i*ADDR_W +: ADDR_W];
          sel_wdata  = dma_wdata[i*DATA_W +: DATA_W];
          sel_we     = dma_we[i];
          sel_ack[i] = 1'b1;
        end
      end
    end
  end

  // CPU6 advances on the same edge that captures its access.
  assign cpu_ready = !reset && cpu_req && (nxt_state == ST_CPU);
  assign owner     = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cur_idx   <= 2'd0;
      rr        <= 2'd0;
      starve    <= 8'd0;
      dma_ack   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      state   <= nxt_state;
      cur_idx <= nxt_idx;
      rr      <= nxt_rr;
      starve  <= nxt_starve;
      dma_ack <= sel_ack;
      if (nxt_state != ST_IDLE) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        mem_we    <= sel_we;
      end else begin
        mem_we <= 1'b0;
      end
      // Read return: capture the bus data at the end of the slot it was driven in.
      if (state == ST_CPU && !mem_we) cpu_rdata <= mem_rdata;
      if (state == ST_DMA && !mem_we) dma_rdata <= mem_rdata;
    end
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single 16-bit address / 8-bit data memory bus between the CPU6 core and NUM_DMA DMA requesters (disk, console/front-panel).
- Sits between CPU6's addressBus/dataOutBus/writeEnBus/dataInBus and the memory/peripheral decode.
- Owns a per-cycle grant state machine with round-robin DMA priority, CPU starvation protection, and a registered read-return path.
- Stalls CPU6 through cpu_ready whenever the CPU does not own the bus.

Parameters:
- NUM_DMA, 2: number of DMA requesters (1..4).
- HOLD_MAX, 8: maximum consecutive DMA-owned cycles while cpu_req is high before the CPU is forced one slot (1..255).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_req  in  1  CPU requests a bus cycle this clock.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_ready  out  1  CPU cycle accepted this clock; CPU holds its request while low.
- cpu_rdata  out  8  registered read data for the CPU.
- dma_req  in  NUM_DMA  per-requester request, held until dma_ack.
- dma_we  in  NUM_DMA  per-requester write flag.
- dma_addr  in  16*NUM_DMA  packed addresses; requester i at [16i+15:16i].
- dma_wdata  in  8*NUM_DMA  packed write data.
- dma_ack  out  NUM_DMA  one-hot one-cycle pulse: request accepted on the bus this clock.
- dma_rdata  out  8  registered read data, valid the cycle after dma_ack.
- mem_addr  out  16  registered bus address.
- mem_wdata  out  8  registered bus write data.
- mem_we  out  1  registered bus write strobe.
- mem_rdata  in  8  bus read data, valid in the cycle mem_addr is driven.
- owner  out  2  current owner: 0 = none, 1 = CPU, 2 = DMA.

Behaviour:
- Reset values: mem_addr = 0, mem_wdata = 0, mem_we = 0, cpu_rdata = 0, dma_rdata = 0, dma_ack = 0, owner = 0, rr pointer = 0, starve counter = 0. cpu_ready is combinational and reads 0 during reset.
- State machine: IDLE / CPU / DMA. The state names the owner of the bus slot driven this cycle. The next state is chosen from the requests sampled at each rising edge.
- Arbitration at each edge, in priority order:
  - (a) If cpu_req and starve == HOLD_MAX: CPU wins and starve clears.
  - (b) Else if any dma_req: DMA wins. The lowest index at or after the rr pointer (wrapping modulo NUM_DMA) is selected, and rr becomes winner+1 mod NUM_DMA. starve increments (saturating at HOLD_MAX) only if cpu_req is high.
  - (c) Else if cpu_req: CPU wins and starve clears.
  - (d) Else: IDLE, mem_we = 0, mem_addr holds its value.
- cpu_ready = cpu_req and (the arbitration outcome this cycle is CPU), so CPU6 advances on the same edge its cycle is captured.
- dma_ack[i] is asserted in the cycle following the edge at which i won, i.e. while its address is on mem_addr.
- Latency: request edge N → bus driven in cycle N+1 → cpu_rdata/dma_rdata captured from mem_rdata at edge N+2. Read data for a write cycle is not updated.
- mem_we is 1 only for the single cycle of an accepted write; a requester holding its request gets no repeated strobe until re-arbitrated.
- Back-to-back: one access per clock with no dead cycle between owners.
- Reset mid-operation: the in-flight cycle is abandoned and mem_we drops immediately (asynchronous). No ack is issued for it.
- A dma_req dropped before its ack is simply not served.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Enabled: adds input dma_lock[NUM_DMA]. While the current DMA owner holds dma_lock, it keeps winning (burst) with rr frozen, but the starve rule (a) still preempts.
- Disabled: no port, and every cycle re-arbitrates.

Decomposition:
- Shared package: owner encoding constants (OWN_NONE, OWN_CPU, OWN_DMA), state encoding, and address/data width constants (16/8).
- One natural sub-module: rr_picker, a combinational round-robin priority encoder taking (req vector, rr pointer) and producing (grant index, valid).

Test Plan:
- CPU only: cpu_req=1, read 0x1234 → cpu_ready=1 same cycle, mem_addr=0x1234 next cycle, cpu_rdata = mem_rdata (0xA5) one cycle later.
- Two DMA requesters continuously requesting, no cpu_req → grants alternate 0,1,0,1, with dma_ack one-hot each cycle.
- DMA0 continuous plus cpu_req=1 with HOLD_MAX=8 → 8 DMA cycles, then one CPU cycle (cpu_ready=1), repeating; starve never exceeds 8.
- DMA1 write 0x0F00 ← 0x5A → mem_we high exactly one cycle with mem_addr=0x0F00 and mem_wdata=0x5A.
- Reset asserted during a write cycle → mem_we=0 immediately, owner=0, no dma_ack after release.
- ARB_LOCK_EN: DMA0 holds dma_lock for 4 cycles while DMA1 requests → DMA0 gets 4 consecutive acks, then DMA1 is served.
